scan_dac_writer: RTL and testbench
==================================

SCAN_DAC_WRITER -- requirements
Module: scan_dac_writer

Interface
REQ-001 Parameter CLK_DIV, default 4, is the clk cycles per sclk half-period; legal range 2..255.
REQ-002 Parameter CMD, default 8'h30, is the command byte prefixed to each DAC frame (write-and-update).
REQ-003 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port enable, input, 1 bit: accept new scan values when high.
REQ-006 Port din, input, 16 bits: scan value from the upstream scan generator q output.
REQ-007 Port din_upd, input, 1 bit: single-cycle strobe that din is valid; driven by the scan generator output_upd.
REQ-008 Port overrun_clr, input, 1 bit: clears the overrun flag.
REQ-009 Port sclk, output, 1 bit: DAC serial clock.
REQ-010 Port sdo, output, 1 bit: DAC serial data, MSB first.
REQ-011 Port sync_n, output, 1 bit: active-low DAC frame select.
REQ-012 Port busy, output, 1 bit: high while a frame is in progress.
REQ-013 Port overrun, output, 1 bit: sticky; set when a pending value is overwritten.

Function
REQ-014 The frame SHALL be 24 bits, {CMD, din}, sent MSB first.
REQ-015 A one-deep pending register SHALL latch din on din_upd when enable is high.
REQ-016 States SHALL be IDLE, SETUP, SHIFT and HOLD.
REQ-017 IDLE with pending valid SHALL load the shift register, clear pending and enter SETUP on the next clk.
REQ-018 Latency: din_upd at cycle 0 with the block idle SHALL give sync_n low and busy high at cycle 1.
REQ-019 SETUP: sync_n low, sclk low and sdo equal to frame bit 23 for CLK_DIV cycles, then enter SHIFT.
REQ-020 SHIFT: 24 sclk periods, each high for CLK_DIV cycles then low for CLK_DIV cycles.
REQ-021 sdo SHALL change only on sclk high-to-low transitions, so it is stable at each rising edge, where the DAC samples.
REQ-022 sdo SHALL be 0 after the 24th bit.
REQ-023 After the 24th low phase, the block SHALL enter HOLD with sync_n high and sclk low for CLK_DIV cycles, then enter IDLE.
REQ-024 Each frame SHALL occupy exactly 50*CLK_DIV cycles of busy, of which sync_n is low for 49*CLK_DIV.
REQ-025 din_upd during a frame with pending empty SHALL fill pending without setting overrun.
REQ-026 din_upd with pending full SHALL overwrite pending with the newest value and set overrun.
REQ-027 din_upd in the same cycle that pending is consumed into the shift register SHALL refill pending without setting overrun.
REQ-028 overrun_clr asserted in the same cycle as a new overrun event SHALL leave overrun set.
REQ-029 enable low SHALL ignore din_upd and clear pending, and the current frame SHALL still complete.
REQ-030 In IDLE the outputs SHALL be sync_n=1, sclk=0 and sdo=0.

Reset
REQ-031 rst_n low SHALL immediately force state to IDLE, pending invalid, sync_n=1, sclk=0, sdo=0, busy=0 and overrun=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame, and no partial frame SHALL resume after release.
REQ-033 The first frame after reset release SHALL start only on a new din_upd.

Configuration
REQ-034 With macro SCAN_DAC_OVERRUN_CNT_EN defined, an output overrun_count of 16 bits SHALL be added.
REQ-035 overrun_count SHALL increment on each overrun event, saturate at 16'hFFFF, and clear on overrun_clr; it resets to 0.
REQ-036 Without SCAN_DAC_OVERRUN_CNT_EN, the overrun_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-037 Package scan_dac_pkg SHALL hold the state enumeration, FRAME_W=24, DATA_W=16 and the default CMD constant.
REQ-038 Sub-module scan_dac_clkdiv SHALL generate the half-period tick from CLK_DIV; it is restarted on entry to SETUP.

Verification
REQ-039 CLK_DIV=4, single din_upd with din=16'h1234: sync_n is low for 196 cycles, sclk shows 24 rising edges, the sampled word is 24'h301234, and busy is high for 200 cycles.
REQ-040 Ramp stimulus (scan_min=0, scan_max=16'h1FFF, increment=16'h100, one update every 300 cycles): every value is transmitted in order and overrun stays 0.
REQ-041 Three din_upd pulses (16'h0100, 16'h0200, 16'h0300) 10 cycles apart while idle: frames carry 16'h0100 then 16'h0300, overrun=1, and overrun_count=1 when the macro is enabled.
REQ-042 rst_n pulsed low at cycle 50 of a frame: sync_n=1 and sclk=0 in the same cycle, no further sclk edges occur, and overrun=0.
REQ-043 enable=0 with din_upd pulses: no frame starts; a frame already in progress completes and no pending frame follows.
REQ-044 overrun_clr coincident with an overwriting din_upd: overrun remains 1; overrun_clr alone on the next cycle: overrun becomes 0.

Source files
------------

// File: rtl/scan_dac_pkg.sv
// Shared types and constants for the scan DAC writer.
// Frame geometry, FSM states and the default DAC command byte.
package scan_dac_pkg;

  localparam int unsigned FRAME_W = 24;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CMD_W   = 8;
  localparam int unsigned BITS_W  = 5;

  localparam logic [CMD_W-1:0] CMD_DEFAULT = 8'h30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_e;

  function automatic logic [FRAME_W-1:0] mk_frame(
    input logic [CMD_W-1:0]  cmd,
    input logic [DATA_W-1:0] data
  );
    return {cmd, data};
  endfunction

endpackage

// File: rtl/scan_dac_clkdiv.sv
// Half-period tick generator for the DAC serial clock.
// Ports: clk, rst_n, restart_i (hold counter at 0), tick_o (every CLK_DIV).
module scan_dac_clkdiv #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick_o = !restart_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_dac_writer.sv
// Serialises scan values as 24-bit {CMD, din} DAC frames, MSB first.
// Ports: clk, rst_n, enable, din, din_upd, overrun_clr in; sclk, sdo,
// sync_n, busy, overrun out. SCAN_DAC_OVERRUN_CNT_EN adds overrun_count.
module scan_dac_writer
  import scan_dac_pkg::*;
#(
  parameter int unsigned      CLK_DIV = 4,
  parameter logic [CMD_W-1:0] CMD     = CMD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] din,
  input  logic              din_upd,
  input  logic              overrun_clr,
  output logic              sclk,
  output logic              sdo,
  output logic              sync_n,
  output logic              busy,
  output logic              overrun
`ifdef SCAN_DAC_OVERRUN_CNT_EN
  ,
  output logic [15:0]       overrun_count
`endif
);

  state_e              state_q;
  state_e              state_d;
  logic [FRAME_W-1:0]  shift_q;
  logic [FRAME_W-1:0]  shift_d;
  logic [BITS_W-1:0]   bits_q;
  logic [BITS_W-1:0]   bits_d;
  logic                sclk_q;
  logic                sclk_d;
  logic                pend_v_q;
  logic                pend_v_d;
  logic [DATA_W-1:0]   pend_q;
  logic [DATA_W-1:0]   pend_d;
  logic                ovr_q;
  logic                ovr_d;

  logic idle;
  logic upd;
  logic start;
  logic ovr_evt;
  logic tick;

  localparam logic [BITS_W-1:0] LAST_BIT =
    BITS_W'(FRAME_W - 1);

  assign idle  = (state_q == IDLE);
  assign upd   = enable && din_upd;
  assign start = idle && enable && (pend_v_q || din_upd);
  // Consumption in IDLE frees the slot, so only a busy block overruns.
  assign ovr_evt = upd && pend_v_q && !idle;

  scan_dac_clkdiv #(
    .CLK_DIV (CLK_DIV)
  ) u_clkdiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (idle),
    .tick_o    (tick)
  );

  // Pending slot: an idle block with an empty slot sends din directly.
  always_comb begin
    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    if (!enable) begin
      pend_v_d = 1'b0;
    end else if (din_upd) begin
      pend_d   = din;
      pend_v_d = !(idle && !pend_v_q);
    end else if (idle && pend_v_q) begin
      pend_v_d = 1'b0;
    end
  end

  always_comb begin
    ovr_d = ovr_evt || (ovr_q && !overrun_clr);
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bits_d  = bits_q;
    sclk_d  = sclk_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = mk_frame(CMD, pend_v_q ? pend_q : din);
          bits_d  = '0;
          sclk_d  = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            // Falling edge: advance data; zeros fill in behind.
            sclk_d  = 1'b0;
            shift_d = shift_q << 1;
          end else if (bits_q == LAST_BIT) begin
            state_d = HOLD;
          end else begin
            sclk_d  = 1'b1;
            bits_d  = bits_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bits_q   <= '0;
      sclk_q   <= 1'b0;
      pend_v_q <= 1'b0;
      pend_q   <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bits_q   <= bits_d;
      sclk_q   <= sclk_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
    end
  end

`ifdef SCAN_DAC_OVERRUN_CNT_EN
  logic [15:0] ocnt_q;
  logic [15:0] ocnt_d;

  // A clear and a new event together leave a count of one.
  always_comb begin
    ocnt_d = overrun_clr ? 16'd0 : ocnt_q;
    if (ovr_evt && (ocnt_d != 16'hFFFF)) begin
      ocnt_d = ocnt_d + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ocnt_q <= '0;
    end else begin
      ocnt_q <= ocnt_d;
    end
  end

  assign overrun_count = ocnt_q;
`endif

  assign sync_n  = !((state_q == SETUP) || (state_q == SHIFT));
  assign sclk    = sclk_q;
  assign sdo     = shift_q[FRAME_W-1] && !sync_n;
  assign busy    = !idle;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_scan_dac_writer.sv
// Directed bench for scan_dac_writer with CLK_DIV=4, CMD=8'h30.
// Decodes frames from sclk/sdo and checks timing and overrun handling.
module tb_scan_dac_writer;

  localparam logic [7:0] CMD = 8'h30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] din = '0;
  logic        din_upd = 1'b0;
  logic        overrun_clr = 1'b0;
  logic        sclk;
  logic        sdo;
  logic        sync_n;
  logic        busy;
  logic        overrun;
`ifdef SCAN_DAC_OVERRUN_CNT_EN
  logic [15:0] overrun_count;
`endif

  int nchk = 0;
  int nfail = 0;

  scan_dac_writer #(
    .CLK_DIV (4),
    .CMD     (8'h30)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .din         (din),
    .din_upd     (din_upd),
    .overrun_clr (overrun_clr),
    .sclk        (sclk),
    .sdo         (sdo),
    .sync_n      (sync_n),
    .busy        (busy),
    .overrun     (overrun)
`ifdef SCAN_DAC_OVERRUN_CNT_EN
    ,
    .overrun_count (overrun_count)
`endif
  );

  always #5 clk = ~clk;

  // Frame monitor, sampled on the falling clk edge.
  logic [23:0] cap = '0;
  int          nedge = 0;
  int          lowc = 0;
  int          busyc = 0;
  int          tot_edges = 0;
  int          viol = 0;
  logic        sclk_p = 1'b0;
  logic        sync_p = 1'b1;
  logic        busy_p = 1'b0;
  logic        sdo_p = 1'b0;
  logic [23:0] fw[$];
  int          fe[$];
  int          fl[$];
  int          fb[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      cap   <= '0;
      nedge <= 0;
      lowc  <= 0;
      busyc <= 0;
    end else begin
      if (sclk && !sclk_p) begin
        cap       <= {cap[22:0], sdo};
        nedge     <= nedge + 1;
        tot_edges <= tot_edges + 1;
      end
      if (sclk && sclk_p && (sdo !== sdo_p)) viol <= viol + 1;
      if (!sync_n) lowc <= lowc + 1;
      if (busy) busyc <= busyc + 1;
      if (sync_n && !sync_p) begin
        fw.push_back(cap);
        fe.push_back(nedge);
        fl.push_back(lowc);
        cap   <= '0;
        nedge <= 0;
        lowc  <= 0;
      end
      if (!busy && busy_p) begin
        fb.push_back(busyc);
        busyc <= 0;
      end
    end
    sclk_p <= sclk;
    sync_p <= sync_n;
    busy_p <= busy;
    sdo_p  <= sdo;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] v);
    din     = v;
    din_upd = 1'b1;
    tick();
    din_upd = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    nchk++;
    if (busy !== 1'b0) begin
      nfail++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, want 0",
               busy, max);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    nchk++;
    if ({sync_n, sclk, sdo, busy, overrun} !== 5'b10000) begin
      nfail++;
      $display("FAIL reset_outs: got %b want 10000",
               {sync_n, sclk, sdo, busy, overrun});
    end
`ifdef SCAN_DAC_OVERRUN_CNT_EN
    nchk++;
    if (overrun_count !== 16'd0) begin
      nfail++;
      $display("FAIL reset_cnt: got %0d want 0", overrun_count);
    end
`endif
    rst_n = 1'b1;
    repeat (20) tick();
    nchk++;
    if (busy !== 1'b0 || sync_n !== 1'b1) begin
      nfail++;
      $display("FAIL reset_nostart: busy=%b sync_n=%b want 0 1",
               busy, sync_n);
    end
  endtask

  task automatic test_single_frame();
    int f0 = fw.size();
    int b0 = fb.size();
    int v0 = viol;
    pulse(16'h1234);
    nchk++;
    if ({sync_n, busy, sclk, sdo} !== 4'b0100) begin
      nfail++;
      $display("FAIL latency: sync_n,busy,sclk,sdo=%b want 0100",
               {sync_n, busy, sclk, sdo});
    end
    repeat (193) tick();
    nchk++;
    if ({sync_n, sclk, sdo} !== 3'b000) begin
      nfail++;
      $display("FAIL tail_sdo: sync_n,sclk,sdo=%b want 000",
               {sync_n, sclk, sdo});
    end
    wait_idle(400);
    nchk++;
    if (fw.size() != f0 + 1 || fb.size() != b0 + 1) begin
      nfail++;
      $display("FAIL single_cnt: frames=%0d busy=%0d want 1 1",
               fw.size() - f0, fb.size() - b0);
    end else begin
      nchk++;
      if (fw[f0] !== 24'h301234) begin
        nfail++;
        $display("FAIL single_word: got %h want 301234", fw[f0]);
      end
      nchk++;
      if (fe[f0] != 24) begin
        nfail++;
        $display("FAIL single_edges: got %0d want 24", fe[f0]);
      end
      nchk++;
      if (fl[f0] != 196) begin
        nfail++;
        $display("FAIL single_sync: got %0d want 196", fl[f0]);
      end
      nchk++;
      if (fb[b0] != 200) begin
        nfail++;
        $display("FAIL single_busy: got %0d want 200", fb[b0]);
      end
    end
    nchk++;
    if (viol != v0) begin
      nfail++;
      $display("FAIL sdo_stable: got %0d changes want 0", viol - v0);
    end
  endtask

  task automatic test_overrun();
    int f0 = fw.size();
    pulse(16'h0100);
    repeat (9) tick();
    pulse(16'h0200);
    repeat (9) tick();
    pulse(16'h0300);
    repeat (450) tick();
    nchk++;
    if (fw.size() != f0 + 2) begin
      nfail++;
      $display("FAIL ovr_cnt: got %0d frames want 2", fw.size() - f0);
    end else begin
      nchk++;
      if (fw[f0] !== 24'h300100 || fw[f0+1] !== 24'h300300) begin
        nfail++;
        $display("FAIL ovr_words: got %h %h want 300100 300300",
                 fw[f0], fw[f0+1]);
      end
    end
    nchk++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL ovr_flag: overrun=%b busy=%b want 1 0",
               overrun, busy);
    end
`ifdef SCAN_DAC_OVERRUN_CNT_EN
    nchk++;
    if (overrun_count !== 16'd1) begin
      nfail++;
      $display("FAIL ovr_count: got %0d want 1", overrun_count);
    end
`endif
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    nchk++;
    if (overrun !== 1'b0) begin
      nfail++;
      $display("FAIL ovr_clear: got %b want 0", overrun);
    end
  endtask

  task automatic test_overrun_clr();
    int f0 = fw.size();
    pulse(16'hAAAA);
    repeat (4) tick();
    pulse(16'hBBBB);
    nchk++;
    if (overrun !== 1'b0) begin
      nfail++;
      $display("FAIL fill_no_ovr: got %b want 0", overrun);
    end
    repeat (4) tick();
    overrun_clr = 1'b1;
    pulse(16'hCCCC);
    overrun_clr = 1'b0;
    nchk++;
    if (overrun !== 1'b1) begin
      nfail++;
      $display("FAIL clr_coinc: got %b want 1", overrun);
    end
`ifdef SCAN_DAC_OVERRUN_CNT_EN
    nchk++;
    if (overrun_count !== 16'd1) begin
      nfail++;
      $display("FAIL clr_coinc_cnt: got %0d want 1", overrun_count);
    end
`endif
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    nchk++;
    if (overrun !== 1'b0) begin
      nfail++;
      $display("FAIL clr_alone: got %b want 0", overrun);
    end
`ifdef SCAN_DAC_OVERRUN_CNT_EN
    nchk++;
    if (overrun_count !== 16'd0) begin
      nfail++;
      $display("FAIL clr_alone_cnt: got %0d want 0", overrun_count);
    end
`endif
    repeat (450) tick();
    nchk++;
    if (fw.size() != f0 + 2) begin
      nfail++;
      $display("FAIL clr_frames: got %0d want 2", fw.size() - f0);
    end else begin
      nchk++;
      if (fw[f0] !== 24'h30AAAA || fw[f0+1] !== 24'h30CCCC) begin
        nfail++;
        $display("FAIL clr_words: got %h %h want 30aaaa 30cccc",
                 fw[f0], fw[f0+1]);
      end
    end
  endtask

  task automatic test_enable();
    int f0 = fw.size();
    enable = 1'b0;
    pulse(16'h1111);
    repeat (5) tick();
    pulse(16'h2222);
    repeat (50) tick();
    nchk++;
    if (busy !== 1'b0 || fw.size() != f0) begin
      nfail++;
      $display("FAIL en_off: busy=%b frames=%0d want 0 0",
               busy, fw.size() - f0);
    end
    enable = 1'b1;
    pulse(16'h5A5A);
    repeat (20) tick();
    pulse(16'h6B6B);
    tick();
    enable = 1'b0;
    repeat (500) tick();
    enable = 1'b1;
    repeat (50) tick();
    nchk++;
    if (fw.size() != f0 + 1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL en_drop: frames=%0d busy=%b want 1 0",
               fw.size() - f0, busy);
    end else begin
      nchk++;
      if (fw[f0] !== 24'h305A5A) begin
        nfail++;
        $display("FAIL en_word: got %h want 305a5a", fw[f0]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int f0;
    int e0;
    pulse(16'h0F0F);
    pulse(16'h1010);
    pulse(16'h2020);
    repeat (47) tick();
    nchk++;
    if (overrun !== 1'b1 || sync_n !== 1'b0) begin
      nfail++;
      $display("FAIL mid_pre: overrun=%b sync_n=%b want 1 0",
               overrun, sync_n);
    end
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({sync_n, sclk, sdo, busy, overrun} !== 5'b10000) begin
      nfail++;
      $display("FAIL mid_abort: got %b want 10000",
               {sync_n, sclk, sdo, busy, overrun});
    end
    f0 = fw.size();
    e0 = tot_edges;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (300) tick();
    nchk++;
    if (tot_edges != e0 || fw.size() != f0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL mid_resume: edges=%0d frames=%0d busy=%b want 0 0 0",
               tot_edges - e0, fw.size() - f0, busy);
    end
  endtask

  task automatic test_ramp();
    int f0 = fw.size();
    int v0 = viol;
    logic [15:0] v;
    for (int i = 0; i < 32; i++) begin
      v = 16'(i * 16'h0100);
      pulse(v);
      repeat (299) tick();
    end
    repeat (50) tick();
    nchk++;
    if (fw.size() != f0 + 32) begin
      nfail++;
      $display("FAIL ramp_cnt: got %0d want 32", fw.size() - f0);
    end else begin
      for (int i = 0; i < 32; i++) begin
        v = 16'(i * 16'h0100);
        nchk++;
        if (fw[f0+i] !== {CMD, v} || fe[f0+i] != 24) begin
          nfail++;
          $display("FAIL ramp_%0d: got %h/%0d want %h/24",
                   i, fw[f0+i], fe[f0+i], {CMD, v});
        end
      end
    end
    nchk++;
    if (overrun !== 1'b0 || viol != v0) begin
      nfail++;
      $display("FAIL ramp_ovr: overrun=%b sdo_chg=%0d want 0 0",
               overrun, viol - v0);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overrun();
    test_overrun_clr();
    test_enable();
    test_reset_midframe();
    test_ramp();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
